branch_resolve_bht: RTL and testbench

//  Parametrised successor of the EX-stage jump/branch controller: resolves JAL, JALR and
//  six RISC-V branch conditions, and adds a PC-indexed table of 2-bit saturating counters.
//  IF consults the table for a taken/not-taken prediction; EX checks the carried prediction,

---
 rtl/branch_resolve_bht.sv | 152 +++++++++++++++
 tb/tb_branch_resolve_bht.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht
// EX-stage jump/branch resolution with a PC-indexed table of 2-bit saturating
// counters. Fetch reads the table for a taken/not-taken guess. EX compares the
// guess carried with the instruction against the real outcome, then drives
// flush and the PC-mux select, trains the counter and counts branch mispredicts.
module branch_resolve_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              if_is_branch,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [1:0]        j_type,
  input  logic [2:0]        branch_t,
  input  logic              ex_pred_taken,
  input  logic              zero,
  input  logic              sign_bit,
  input  logic              borrow,
  output logic              flush,
  output logic [1:0]        pc_sel,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [1:0] J_NONE   = 2'b00;
  localparam logic [1:0] J_JAL    = 2'b01;
  localparam logic [1:0] J_JALR   = 2'b10;
  localparam logic [1:0] J_BRANCH = 2'b11;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_PC4    = 2'b11;

  localparam logic [1:0]        CTR_INIT = 2'b01;
  localparam logic [STAT_W-1:0] CNT_MAX  = {STAT_W{1'b1}};

  // One saturating step of a 2-bit counter: towards 11 when up, else towards 00.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]        r_bht [BHT_DEPTH];
  logic [STAT_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_legal_f3;
  logic              w_taken;
  logic              w_train;
  logic              w_br_mispred;
  logic              w_unused;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // The fetch-side read sees the table as it stands before this edge's training.
  assign if_pred_taken = ~rst & if_is_branch & r_bht[w_if_idx][1];
  assign mispred_cnt   = r_mispred_cnt;

  // Decode funct3 into the real branch outcome; the two reserved codes fall through as not-taken.
  always_comb begin
    w_legal_f3 = 1'b0;
    w_taken    = 1'b0;
    case (branch_t)
      3'b000:  begin w_legal_f3 = 1'b1; w_taken = zero;      end
      3'b001:  begin w_legal_f3 = 1'b1; w_taken = ~zero;     end
      3'b100:  begin w_legal_f3 = 1'b1; w_taken = sign_bit;  end
      3'b101:  begin w_legal_f3 = 1'b1; w_taken = ~sign_bit; end
      3'b110:  begin w_legal_f3 = 1'b1; w_taken = borrow;    end
      3'b111:  begin w_legal_f3 = 1'b1; w_taken = ~borrow;   end
      default: begin w_legal_f3 = 1'b0; w_taken = 1'b0;      end
    endcase
  end

  // Pick flush / PC source, and decide whether to train and count this cycle.
  always_comb begin
    flush        = 1'b0;
    pc_sel       = SEL_SEQ;
    w_train      = 1'b0;
    w_br_mispred = 1'b0;
    if (rst || !ex_valid) begin
      flush  = 1'b0;
      pc_sel = SEL_SEQ;
    end else begin
      case (j_type)
        J_JAL, J_JALR: begin
          flush  = 1'b1;
          pc_sel = SEL_JUMP;
        end
        J_BRANCH: begin
          w_train = w_legal_f3;
          if (w_taken && !ex_pred_taken) begin
            flush        = 1'b1;
            pc_sel       = SEL_BRANCH;
            w_br_mispred = w_legal_f3;
          end else if (!w_taken && ex_pred_taken) begin
            flush        = 1'b1;
            pc_sel       = SEL_PC4;
            w_br_mispred = w_legal_f3;
          end else begin
            flush  = 1'b0;
            pc_sel = SEL_SEQ;
          end
        end
        J_NONE: begin
          flush  = 1'b0;
          pc_sel = SEL_SEQ;
        end
        default: begin
          flush  = 1'b0;
          pc_sel = SEL_SEQ;
        end
      endcase
    end
  end

  // Counter table: bulk re-init to weak not-taken on reset, otherwise train the EX entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= CTR_INIT;
      end
    end else if (w_train) begin
      r_bht[w_ex_idx] <= sat_step(r_bht[w_ex_idx], w_taken);
    end
  end

  // Saturating count of conditional-branch mispredicts (jump flushes are not mispredicts).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispred_cnt <= {STAT_W{1'b0}};
    end else if (w_br_mispred && (r_mispred_cnt != CNT_MAX)) begin
      r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Testbench for branch_resolve_bht: a directed vector table covering the
// prediction/resolution corner cases, then random traffic checked against a
// behavioural model (array of integer counters + saturating stat counts),
// then counter saturation with a 4-bit stat instance and reset mid-operation.
module tb_branch_resolve_bht;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic        if_pred_taken;
  logic        if_pred_taken4;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  j_type;
  logic [2:0]  branch_t;
  logic        ex_pred_taken;
  logic        zero;
  logic        sign_bit;
  logic        borrow;
  logic        flush;
  logic        flush4;
  logic [1:0]  pc_sel;
  logic [1:0]  pc_sel4;
  logic [15:0] mispred_cnt;
  logic [3:0]  mispred_cnt4;

  branch_resolve_bht u_dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_branch(if_is_branch),
    .if_pred_taken(if_pred_taken), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .j_type(j_type), .branch_t(branch_t), .ex_pred_taken(ex_pred_taken),
    .zero(zero), .sign_bit(sign_bit), .borrow(borrow), .flush(flush),
    .pc_sel(pc_sel), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_bht #(.XLEN(32), .BHT_DEPTH(64), .STAT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_branch(if_is_branch),
    .if_pred_taken(if_pred_taken4), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .j_type(j_type), .branch_t(branch_t), .ex_pred_taken(ex_pred_taken),
    .zero(zero), .sign_bit(sign_bit), .borrow(borrow), .flush(flush4),
    .pc_sel(pc_sel4), .mispred_cnt(mispred_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_bht [64];
  int m_cnt16;
  int m_cnt4;

  // Outputs captured mid-cycle by apply(), for directed comparisons
  logic       cap_pred;
  logic       cap_flush;
  logic [1:0] cap_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  // Outcome of a conditional branch from the ALU flags
  function automatic void m_outcome(input logic [2:0] f3, input logic z, input logic s,
                                    input logic b, output bit legal, output bit taken);
    legal = 1'b1;
    case (f3)
      3'd0: taken = z;
      3'd1: taken = !z;
      3'd4: taken = s;
      3'd5: taken = !s;
      3'd6: taken = b;
      3'd7: taken = !b;
      default: begin legal = 1'b0; taken = 1'b0; end
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_cnt16 = 0;
    m_cnt4  = 0;
  endtask

  // Drive one cycle of inputs, check combinational outputs against the model,
  // then let the edge happen and check the stat counters.
  task automatic apply(input logic ev, input logic [31:0] epc, input logic [1:0] jt,
                       input logic [2:0] f3, input logic z, input logic s, input logic b,
                       input logic p, input logic [31:0] ipc, input logic ib);
    bit legal, taken;
    int xf, xs, xp;
    @(negedge clk);
    ex_valid = ev; ex_pc = epc; j_type = jt; branch_t = f3;
    zero = z; sign_bit = s; borrow = b; ex_pred_taken = p;
    if_pc = ipc; if_is_branch = ib;
    #1;
    m_outcome(f3, z, s, b, legal, taken);
    xp = (ib && m_bht[m_idx(ipc)] >= 2) ? 1 : 0;
    xf = 0; xs = 0;
    if (ev && (jt == 2'd1 || jt == 2'd2)) begin
      xf = 1; xs = 2;
    end else if (ev && jt == 2'd3 && taken && !p) begin
      xf = 1; xs = 1;
    end else if (ev && jt == 2'd3 && !taken && p) begin
      xf = 1; xs = 3;
    end
    cap_pred = if_pred_taken; cap_flush = flush; cap_sel = pc_sel;
    chk("model_pred", {31'd0, if_pred_taken}, xp);
    chk("model_flush", {31'd0, flush}, xf);
    chk("model_pc_sel", {30'd0, pc_sel}, xs);
    chk("model_pc_sel_s4", {30'd0, pc_sel4}, xs);
    @(posedge clk);
    #1;
    if (ev && jt == 2'd3 && legal) begin
      if (taken) m_bht[m_idx(epc)] = (m_bht[m_idx(epc)] == 3) ? 3 : m_bht[m_idx(epc)] + 1;
      else       m_bht[m_idx(epc)] = (m_bht[m_idx(epc)] == 0) ? 0 : m_bht[m_idx(epc)] - 1;
      if (taken != p) begin
        m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
        m_cnt4  = (m_cnt4 == 15) ? 15 : m_cnt4 + 1;
      end
    end
    chk("model_cnt16", {16'd0, mispred_cnt}, m_cnt16);
    chk("model_cnt4", {28'd0, mispred_cnt4}, m_cnt4);
  endtask

  // Reset with a live branch sitting in EX: outputs must be forced low and it must not train.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ex_valid = 1'b1; ex_pc = 32'h40; j_type = 2'd3; branch_t = 3'd0;
    zero = 1'b1; sign_bit = 1'b0; borrow = 1'b0; ex_pred_taken = 1'b0;
    if_pc = $urandom() & 32'hFFFF_FFFC; if_is_branch = 1'b1;
    #1;
    chk("rst_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    m_reset();
    chk("rst_cnt16", {16'd0, mispred_cnt}, 32'd0);
    chk("rst_cnt4", {28'd0, mispred_cnt4}, 32'd0);
  endtask

  typedef struct {
    logic        ev;
    logic [31:0] epc;
    logic [1:0]  jt;
    logic [2:0]  f3;
    logic        z, s, b, p;
    logic [31:0] ipc;
    logic        ib;
    logic        xpred, xflush;
    logic [1:0]  xsel;
    int          xcnt;
  } vec_t;

  function automatic vec_t mk(input logic ev, input logic [31:0] epc, input logic [1:0] jt,
                              input logic [2:0] f3, input logic z, input logic s,
                              input logic b, input logic p, input logic [31:0] ipc,
                              input logic ib, input logic xpred, input logic xflush,
                              input logic [1:0] xsel, input int xcnt);
    vec_t v;
    v.ev = ev; v.epc = epc; v.jt = jt; v.f3 = f3; v.z = z; v.s = s; v.b = b; v.p = p;
    v.ipc = ipc; v.ib = ib; v.xpred = xpred; v.xflush = xflush; v.xsel = xsel; v.xcnt = xcnt;
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    // ev  ex_pc   jt  f3  z s b p   if_pc   ib  pred flush sel cnt(after edge)
    tbl[0]  = mk(1, 32'h40,  3, 0, 1,0,0,0, 32'h40,  1, 0, 1, 1, 1); // BEQ taken, bht 01->10
    tbl[1]  = mk(0, 32'h40,  3, 0, 1,0,0,0, 32'h40,  1, 1, 0, 0, 1); // new value visible
    tbl[2]  = mk(1, 32'h40,  3, 0, 1,0,0,1, 32'h40,  1, 1, 0, 0, 1); // 10->11
    tbl[3]  = mk(1, 32'h40,  3, 0, 1,0,0,1, 32'h40,  1, 1, 0, 0, 1); // stays 11
    tbl[4]  = mk(1, 32'h40,  3, 0, 1,0,0,1, 32'h40,  1, 1, 0, 0, 1); // stays 11
    tbl[5]  = mk(1, 32'h40,  3, 0, 0,0,0,1, 32'h40,  1, 1, 1, 3, 2); // not taken, 11->10
    tbl[6]  = mk(0, 32'h40,  3, 0, 0,0,0,0, 32'h40,  1, 1, 0, 0, 2); // still predicts taken
    tbl[7]  = mk(1, 32'h80,  3, 6, 0,0,1,0, 32'h80,  1, 0, 1, 1, 3); // BLTU borrow=1 taken
    tbl[8]  = mk(1, 32'h84,  3, 4, 0,0,1,0, 32'h84,  1, 0, 0, 0, 3); // BLT sign=0 not taken
    tbl[9]  = mk(1, 32'h40,  2, 0, 0,0,0,0, 32'h40,  1, 1, 1, 2, 3); // JALR
    tbl[10] = mk(1, 32'h40,  1, 0, 0,0,0,1, 32'h40,  0, 0, 1, 2, 3); // JAL, ib=0
    tbl[11] = mk(0, 32'h40,  2, 0, 0,0,0,0, 32'h40,  1, 1, 0, 0, 3); // bubble JALR, bht untouched
    tbl[12] = mk(1, 32'h40,  3, 2, 1,0,0,0, 32'h40,  1, 1, 0, 0, 3); // funct3 010
    tbl[13] = mk(1, 32'h40,  3, 3, 1,0,0,0, 32'h40,  1, 1, 0, 0, 3); // funct3 011
    tbl[14] = mk(1, 32'h40,  3, 1, 0,0,0,1, 32'h40,  1, 1, 0, 0, 3); // BNE taken ok, 10->11
    tbl[15] = mk(1, 32'hC0,  3, 5, 0,1,0,0, 32'hC0,  1, 0, 0, 0, 3); // BGE not taken, 01->00
    tbl[16] = mk(1, 32'hC4,  3, 7, 0,0,0,0, 32'hC4,  1, 0, 1, 1, 4); // BGEU taken, 01->10
    tbl[17] = mk(0, 32'h0,   0, 0, 0,0,0,0, 32'hC4,  1, 1, 0, 0, 4);
    tbl[18] = mk(0, 32'h0,   0, 0, 0,0,0,0, 32'h140, 1, 1, 0, 0, 4); // alias of 0x40 (11)
    tbl[19] = mk(1, 32'h140, 3, 1, 1,0,0,1, 32'h40,  1, 1, 1, 3, 5); // train via alias 11->10
    tbl[20] = mk(1, 32'h140, 3, 0, 0,0,0,0, 32'h40,  1, 1, 0, 0, 5); // 10->01, IF sees old
    tbl[21] = mk(0, 32'h0,   0, 0, 0,0,0,0, 32'h40,  1, 0, 0, 0, 5); // 0x40 now weak NT

    rst = 1'b1; ex_valid = 1'b0; ex_pc = 32'd0; j_type = 2'd0; branch_t = 3'd0;
    ex_pred_taken = 1'b0; zero = 1'b0; sign_bit = 1'b0; borrow = 1'b0;
    if_pc = 32'd0; if_is_branch = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // After reset nothing is predicted taken
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 32'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, ($urandom() & 32'hFFFF_FFFC), 1'b1);
      chk("init_pred", {31'd0, cap_pred}, 32'd0);
    end

    // Directed vector table
    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].ev, tbl[i].epc, tbl[i].jt, tbl[i].f3, tbl[i].z, tbl[i].s, tbl[i].b,
            tbl[i].p, tbl[i].ipc, tbl[i].ib);
      chk($sformatf("vec%0d_pred", i), {31'd0, cap_pred}, {31'd0, tbl[i].xpred});
      chk($sformatf("vec%0d_flush", i), {31'd0, cap_flush}, {31'd0, tbl[i].xflush});
      chk($sformatf("vec%0d_pc_sel", i), {30'd0, cap_sel}, {30'd0, tbl[i].xsel});
      chk($sformatf("vec%0d_cnt", i), {16'd0, mispred_cnt}, tbl[i].xcnt);
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] epc, ipc;
      logic [2:0]  f3;
      logic        p;
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        epc = ($urandom_range(0, 15) * 4) + ($urandom_range(0, 3) * 32'h100);
        ipc = ($urandom_range(0, 2) == 0) ? epc
              : ($urandom_range(0, 15) * 4) + ($urandom_range(0, 3) * 32'h100);
        f3  = 3'($urandom_range(0, 7));
        p   = 1'($urandom_range(0, 1));
        if (f3 == 3'd2 || f3 == 3'd3) p = 1'b0;
        apply(($urandom_range(0, 7) != 0), epc,
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3, f3,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              p, ipc, 1'($urandom_range(0, 1)));
      end
    end

    // Stat saturation: 20 mispredicts
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 32'h200, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1);
    end
    chk("sat_cnt4", {28'd0, mispred_cnt4}, 32'd15);
    chk("sat_cnt16", {16'd0, mispred_cnt}, 32'd20);
    apply(1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1);
    chk("sat_bht_pred", {31'd0, cap_pred}, 32'd1);

    // Reset mid-operation clears counters and table
    do_reset();
    chk("post_rst_cnt4", {28'd0, mispred_cnt4}, 32'd0);
    apply(1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1);
    chk("post_rst_pred", {31'd0, cap_pred}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
